// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS signed MAC array with input skew, zero-flush drain,
// saturating accumulation and row-by-row readout under a start/done FSM.
module systolic_mm_engine #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int KMAX    = 255,
    localparam int KW     = $clog2(KMAX + 1),
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      accumulate,
    input  logic [KW-1:0]             k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*BITS_AB-1:0]   a_data,
    input  logic [COLS*BITS_AB-1:0]   b_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*BITS_C-1:0]    out_data,
    output logic [RW-1:0]             out_row,
    output logic                      busy,
    output logic                      done,
    output logic                      sat
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READ} state_t;

    localparam int DRAIN_LEN = ROWS + COLS - 2;
    localparam int DW        = $clog2(ROWS + COLS);
    localparam int CW        = (KW > DW) ? KW : DW;

    localparam logic signed [BITS_C:0] SMAX = {2'b00, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C:0] SMIN = {2'b11, {(BITS_C-1){1'b0}}};

    // Returns {clamped, acc + a*b clamped to the BITS_C signed range}.
    function automatic logic [BITS_C:0] sat_mac(input logic signed [BITS_C-1:0] acc,
                                                input logic signed [BITS_AB-1:0] a,
                                                input logic signed [BITS_AB-1:0] b);
        logic signed [2*BITS_AB-1:0] prod;
        logic signed [BITS_C:0]      sum;
        prod = (2*BITS_AB)'(a) * (2*BITS_AB)'(b);
        sum  = (BITS_C+1)'(acc) + (BITS_C+1)'(prod);
        if (sum > SMAX)
            sat_mac = {1'b1, SMAX[BITS_C-1:0]};
        else if (sum < SMIN)
            sat_mac = {1'b1, SMIN[BITS_C-1:0]};
        else
            sat_mac = {1'b0, sum[BITS_C-1:0]};
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   k_q;
    logic [RW-1:0]   row;
    logic            in_load, adv, clr_pipe, clr_acc, sat_any;

    logic signed [BITS_AB-1:0] pe_a   [ROWS][COLS];
    logic signed [BITS_AB-1:0] pe_b   [ROWS][COLS];
    logic signed [BITS_C-1:0]  pe_acc [ROWS][COLS];
    logic                      pe_sat [ROWS][COLS];

    assign in_load  = (state == LOAD);
    assign adv      = (in_load && in_valid) || (state == DRAIN);
    assign clr_pipe = (state == IDLE) && start;
    assign clr_acc  = clr_pipe && !accumulate;

    assign in_ready  = in_load;
    assign busy      = (state != IDLE);
    assign out_valid = (state == READ);
    assign out_row   = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            k_q   <= '0;
            row   <= '0;
            done  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    k_q   <= k_len;
                    cnt   <= '0;
                    sat   <= 1'b0;
                    state <= (k_len != '0) ? LOAD : READ;
                end
                LOAD: if (in_valid) begin
                    if (cnt == CW'(k_q) - CW'(1)) begin
                        cnt   <= '0;
                        state <= (DRAIN_LEN == 0) ? READ : DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(DRAIN_LEN - 1)) begin
                        cnt   <= '0;
                        state <= READ;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                READ: if (out_ready) begin
                    if (row == RW'(ROWS - 1)) begin
                        row   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (adv && sat_any)
                sat <= 1'b1;
        end
    end

    // Edge skew: row i of A and column j of B are delayed by i / j advances.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic signed [BITS_AB-1:0] inj;
        assign inj = in_load ? $signed(a_data[i*BITS_AB +: BITS_AB]) : '0;
        if (i == 0) begin : g_nodly
            assign pe_a[i][0] = inj;
        end else begin : g_dly
            logic signed [BITS_AB-1:0] sr [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr_pipe) begin
                    for (int d = 0; d < i; d++) sr[d] <= '0;
                end else if (adv) begin
                    sr[0] <= inj;
                    for (int d = 1; d < i; d++) sr[d] <= sr[d-1];
                end
            end
            assign pe_a[i][0] = sr[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic signed [BITS_AB-1:0] inj;
        assign inj = in_load ? $signed(b_data[j*BITS_AB +: BITS_AB]) : '0;
        if (j == 0) begin : g_nodly
            assign pe_b[0][j] = inj;
        end else begin : g_dly
            logic signed [BITS_AB-1:0] sr [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr_pipe) begin
                    for (int d = 0; d < j; d++) sr[d] <= '0;
                end else if (adv) begin
                    sr[0] <= inj;
                    for (int d = 1; d < j; d++) sr[d] <= sr[d-1];
                end
            end
            assign pe_b[0][j] = sr[j-1];
        end
    end

    // MAC cells: accumulate in place, forward A right and B down one advance later.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic signed [BITS_C-1:0] acc_q;
            logic [BITS_C:0]          mac;
            assign mac           = sat_mac(acc_q, pe_a[i][j], pe_b[i][j]);
            assign pe_sat[i][j]  = mac[BITS_C];
            assign pe_acc[i][j]  = acc_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr_acc)
                    acc_q <= '0;
                else if (adv)
                    acc_q <= mac[BITS_C-1:0];
            end

            if (j < COLS - 1) begin : g_fwd_a
                logic signed [BITS_AB-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || clr_pipe) a_q <= '0;
                    else if (adv)        a_q <= pe_a[i][j];
                end
                assign pe_a[i][j+1] = a_q;
            end

            if (i < ROWS - 1) begin : g_fwd_b
                logic signed [BITS_AB-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || clr_pipe) b_q <= '0;
                    else if (adv)        b_q <= pe_b[i][j];
                end
                assign pe_b[i+1][j] = b_q;
            end
        end
    end

    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                sat_any = sat_any | pe_sat[i][j];
    end

    always_comb begin
        out_data = '0;
        if (state == READ)
            for (int j = 0; j < COLS; j++)
                out_data[j*BITS_C +: BITS_C] = pe_acc[row][j];
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine (4x3 array) checked against a plain
// matrix-product model with per-step saturation.
module tb_systolic_mm_engine;

    localparam int R = 4, C = 3, BA = 8, BC = 16, KM = 15, KW = 4, RW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, accumulate = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              in_valid = 1'b0, in_ready;
    logic [R*BA-1:0]   a_data = '0;
    logic [C*BA-1:0]   b_data = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [C*BC-1:0]   out_data;
    logic [RW-1:0]     out_row;
    logic              busy, done, sat;

    int checks = 0, errors = 0;
    int A [R][KM];
    int B [KM][C];
    int mc [R][C];
    bit msat;
    int lit [R];
    bit use_lit;

    systolic_mm_engine #(.ROWS(R), .COLS(C), .BITS_AB(BA), .BITS_C(BC), .KMAX(KM)) dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .busy(busy), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every cycle: a valid row must match the model, an invalid one must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                for (int j = 0; j < C; j++)
                    chk("out_data", longint'($signed(out_data[j*BC +: BC])), mc[out_row][j]);
            end else begin
                chk("out_data_idle", longint'(out_data), 0);
            end
        end
    end

    task automatic model_op(input bit accm, input int k);
        int s;
        msat = 0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                if (!accm) mc[i][j] = 0;
                for (int t = 0; t < k; t++) begin
                    s = mc[i][j] + A[i][t] * B[t][j];
                    if (s > 32767) begin s = 32767; msat = 1; end
                    if (s < -32768) begin s = -32768; msat = 1; end
                    mc[i][j] = s;
                end
            end
    endtask

    task automatic set_const(input int av, input int bv);
        for (int i = 0; i < R; i++) for (int t = 0; t < KM; t++) A[i][t] = av;
        for (int t = 0; t < KM; t++) for (int j = 0; j < C; j++) B[t][j] = bv;
    endtask

    task automatic set_test1();
        int rows [R][4];
        rows = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}, '{0, 0, 0, 1}};
        set_const(0, 1);
        for (int i = 0; i < R; i++) for (int t = 0; t < 4; t++) A[i][t] = rows[i][t];
        lit = '{10, 26, -10, 1};
    endtask

    task automatic start_op(input bit accm, input int k);
        @(posedge clk); #1;
        start = 1'b1; accumulate = accm; k_len = KW'(k);
        model_op(accm, k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int k, input bit stall_in);
        int t = 0, c = 0;
        while (t < k && c < 200) begin
            in_valid = stall_in ? (c % 3 == 0) : 1'b1;
            for (int i = 0; i < R; i++) a_data[i*BA +: BA] = in_valid ? BA'(A[i][t]) : 8'h5a;
            for (int j = 0; j < C; j++) b_data[j*BA +: BA] = in_valid ? BA'(B[t][j]) : 8'ha5;
            @(negedge clk);
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (in_valid) t++;
            c++;
        end
        in_valid = 1'b0;
        if (t < k) chk("feed_timeout", t, k);
    endtask

    task automatic drain_wait();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk("drain_latency", n, R + C - 2);
    endtask

    task automatic readout(input bit stall_out, input bit poke);
        for (int r = 0; r < R; r++) begin
            chk("out_row", out_row, r);
            chk("row_valid", out_valid, 1);
            if (use_lit) chk("lit_c0", longint'($signed(out_data[BC-1:0])), lit[r]);
            if (stall_out)
                repeat (3) begin
                    @(posedge clk); @(negedge clk);
                    chk("stall_row", out_row, r);
                    chk("stall_valid", out_valid, 1);
                end
            out_ready = 1'b1;
            if (poke && r == 1) start = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            start = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        chk("valid_after", out_valid, 0);
        chk("row_after", out_row, 0);
        chk("sat", sat, msat);
        @(posedge clk); @(negedge clk);
        chk("done_once", done, 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Test 1: basic product
        set_test1(); use_lit = 1;
        start_op(0, 4);
        chk("model_pin_26", mc[1][1], 26);
        chk("model_pin_m10", mc[2][2], -10);
        feed(4, 0); drain_wait(); readout(0, 0);

        // Test 2: input and output stalls
        start_op(0, 4);
        feed(4, 1); drain_wait(); readout(1, 0);

        // Test 3: accumulate doubles, then clear with K=1
        start_op(1, 4);
        chk("model_pin_52", mc[1][2], 52);
        lit = '{20, 52, -20, 2};
        feed(4, 0); drain_wait(); readout(0, 0);
        set_const(2, 3); lit = '{6, 6, 6, 6};
        start_op(0, 1);
        feed(1, 0); drain_wait(); readout(0, 0);

        // Test 4: positive and negative saturation
        set_const(127, 127); lit = '{32767, 32767, 32767, 32767};
        start_op(0, 3);
        chk("model_pin_sat", mc[0][0], 32767);
        feed(3, 0); drain_wait();
        chk("sat_pos", sat, 1);
        readout(0, 0);
        set_const(-128, 127); lit = '{-32768, -32768, -32768, -32768};
        start_op(0, 3);
        feed(3, 0); drain_wait();
        chk("sat_neg", sat, 1);
        readout(0, 0);

        // Test 5: K=0 goes straight to READ; start during READ ignored
        lit = '{0, 0, 0, 0};
        start_op(0, 0);
        @(negedge clk);
        chk("k0_in_ready", in_ready, 0);
        chk("k0_valid", out_valid, 1);
        readout(0, 1);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("no_restart_busy", busy, 0);
            chk("no_second_done", done, 0);
        end

        // Test 6: reset mid-LOAD, then accumulate onto the cleared array
        set_test1();
        start_op(0, 4);
        feed(2, 0);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", longint'(out_data), 0);
        chk("abort_row", out_row, 0);
        chk("abort_sat", sat, 0);
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mc[i][j] = 0;
        msat = 0;
        @(posedge clk); #1 rst = 1'b0;
        start_op(1, 4);
        feed(4, 0); drain_wait(); readout(0, 0);

        // Test 7: non-uniform B exercises column skew
        set_const(0, 0);
        A[0][0] = 1;  A[0][1] = 2;  A[1][0] = 3;  A[1][1] = 4;
        A[2][0] = -1; A[2][1] = 0;  A[3][0] = 2;  A[3][1] = -3;
        B[0][0] = 1; B[0][1] = 2; B[0][2] = 3;
        B[1][0] = 4; B[1][1] = 5; B[1][2] = 6;
        lit = '{9, 19, -1, -10};
        start_op(0, 2);
        chk("model_pin_33", mc[1][2], 33);
        chk("model_pin_m12", mc[3][2], -12);
        feed(2, 0); drain_wait(); readout(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Self-contained, parametrised successor of the square systolic MAC grid.
- Holds a ROWS x COLS output-stationary array of signed MAC cells, with built-in input skewing and zero-flush drain.
- Has a start/done control FSM, saturating accumulation and a clear/accumulate mode.
- Streams a ROWS x K by K x COLS product in over a valid/ready port, then returns C row by row over a valid/ready port, for use under the host MMIO layer.

Parameters:
ROWS, 8, number of array rows (rows of A and C), >=1
COLS, 8, number of array columns (columns of B and C), >=1; need not equal ROWS
BITS_AB, 8, signed width of A and B elements
BITS_C, 16, signed width of accumulators and C; must be >= 2*BITS_AB
KMAX, 255, largest supported inner dimension K

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin operation; sampled only in IDLE
accumulate  input  1  sampled with start: 0 = clear accumulators, 1 = add onto existing C
k_len  input  $clog2(KMAX+1)  inner dimension K for this operation, sampled with start
in_valid  input  1  a_data/b_data beat valid
in_ready  output  1  engine accepts a beat (high only in LOAD)
a_data  input  ROWS*BITS_AB  column t of A; element i at bits [i*BITS_AB +: BITS_AB]
b_data  input  COLS*BITS_AB  row t of B; element j at bits [j*BITS_AB +: BITS_AB]
out_valid  output  1  out_data holds a C row
out_ready  input  1  consumer accepts the row
out_data  output  COLS*BITS_C  C[out_row][j] at bits [j*BITS_C +: BITS_C]
out_row  output  $clog2(ROWS) (min 1)  row index of out_data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the operation completes
sat  output  1  sticky: any accumulator saturated during this operation

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all accumulators, skew registers and PE A/B pipeline registers cleared to 0. Outputs: in_ready=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0, sat=0. Reset mid-operation aborts immediately; no partial output.
- Result: C[i][j] (+)= sum over t<K of A[i][t]*B[t][j].
- FSM states: IDLE, LOAD, DRAIN, READ.
- IDLE, start=1: latch k_len and accumulate. Clear skew/pipeline registers and sat. If accumulate=0, clear all accumulators. Next state LOAD if k_len>0, else READ. start while busy is ignored.
- LOAD: in_ready=1. Each cycle with in_valid=1 is a beat and one array advance. A cycle with in_valid=0 freezes the whole array; no state changes. After beat k_len-1, go to DRAIN, or to READ if ROWS+COLS-2=0.
- DRAIN: exactly ROWS+COLS-2 cycles. Each cycle is an advance with zero injected on all A and B edges. Then go to READ.
- Skew: row i A input delayed i advances; column j B input delayed j advances (row 0 / column 0 undelayed). Beat t meets at PE(i,j) on advance t+i+j.
- PE on advance: acc <= sat(acc + A*B). It forwards A right and B down through registers. Edge injections flush through; no garbage from a previous operation.
- Arithmetic: product is the full signed 2*BITS_AB-bit value, sign-extended. The sum is formed at BITS_C+1 bits and clamped to [-2^(BITS_C-1), 2^(BITS_C-1)-1]. Any clamp sets sat; sat holds until the next start.
- READ: out_valid=1; out_row starts at 0; out_data = accumulators of out_row.
  - out_valid && out_ready increments out_row.
  - Handshake on row ROWS-1: next cycle FSM=IDLE, busy=0, done=1 for exactly that one cycle, out_valid=0, out_row=0.
  - out_data is 0 whenever out_valid=0.
- Accumulators are untouched by READ, so a following accumulate=1 operation adds onto them.
- Latency with no stalls: k_len + (ROWS+COLS-2) cycles from first beat to out_valid.

Test Plan:
1. ROWS=4, COLS=3, K=4. A=[[1,2,3,4],[5,6,7,8],[-1,-2,-3,-4],[0,0,0,1]], B=all 1s -> C rows [10,10,10],[26,26,26],[-10,-10,-10],[1,1,1]. out_row 0..3 in order; done one cycle after last handshake.
2. Same data with in_valid toggled 1,0,0,1,... and out_ready low for 3 cycles per row -> identical C; out_data/out_row hold stable while stalled.
3. Run test 1, then start with accumulate=1 and the same inputs -> every C element doubled (20, 52, -20, 2). Then accumulate=0, K=1, A=all 2, B=all 3 -> all C = 6.
4. BITS_AB=8, BITS_C=16, K=3, A=all 127, B=all 127 (3*16129=48387) -> all C = 32767, sat=1. Then A=all -128, B=all 127, K=3, accumulate=0 -> all C = -32768, sat=1.
5. k_len=0, accumulate=0 -> no in_ready cycle; READ returns all-zero rows. Pulse start during READ -> ignored, no restart, single done.
6. Assert rst for 1 cycle mid-LOAD (after 2 of 4 beats) -> busy=0, all outputs 0 immediately. A new operation (test 1 data) gives exact test 1 results.
